// File: rtl/ram_wc_pkg.sv
// Shared constants, FSM encoding and row-pointer sizing for the C-matrix row store.
package ram_wc_pkg;

  localparam int ELEM_W    = 32;
  localparam int ROW_ELEMS = 33;
  localparam int DEPTH     = 33;
  localparam int ROW_W     = ELEM_W * ROW_ELEMS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    FULL  = 2'd3
  } state_t;

  // Pointer must be able to hold DEPTH itself so "all rows written" is representable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W = ptr_width(DEPTH);

endpackage

// File: rtl/ram_write_controller_c_row_mem.sv
// Row-wide, write-only memory for the corrected C matrix; readers reach it hierarchically.
module c_row_mem
  import ram_wc_pkg::*;
#(
  parameter int W  = ROW_W,
  parameter int D  = DEPTH,
  parameter int AW = PTR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  (* keep = "true" *) logic [W-1:0] mem [D];

  // Single synchronous write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/ram_write_controller.sv
// Accepts one corrected row per store_C rising edge, writes it to the row RAM and
// acknowledges it for one cycle; finish rewinds the row pointer.
module ram_write_controller
  import ram_wc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             store_C,
  input  logic             finish,
  input  logic [ROW_W-1:0] dataCf_out,
  output logic             store_C_ready
);

  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

  state_t           state;
  state_t           next_state;
  logic             store_C_q;
  logic             req;
  logic [ROW_W-1:0] row_buf;
  logic [PTR_W-1:0] row_ptr;
  logic             we;
  logic             latch;
  logic             ack_next;

  assign req = store_C & ~store_C_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; finish overrides every state.
  always_comb begin
    next_state = state;
    if (finish) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = req ? WRITE : IDLE;
        WRITE:   next_state = (row_ptr == LAST_ROW) ? FULL : DONE;
        DONE:    next_state = IDLE;
        FULL:    next_state = FULL;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode: latch strobe, RAM write enable and next acknowledge value.
  always_comb begin
    latch    = 1'b0;
    we       = 1'b0;
    ack_next = 1'b0;
    case (state)
      IDLE: begin
        latch = req & ~finish;
      end
      WRITE: begin
        we       = ~finish;
        ack_next = ~finish;
      end
      DONE:    ack_next = 1'b0;
      FULL:    ack_next = 1'b0;
      default: ack_next = 1'b0;
    endcase
  end

  // Edge-detect history, row latch, row pointer and registered acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_C_q     <= 1'b0;
      row_buf       <= {ROW_W{1'b0}};
      row_ptr       <= {PTR_W{1'b0}};
      store_C_ready <= 1'b0;
    end else begin
      store_C_q     <= store_C;
      store_C_ready <= ack_next;
      if (latch) begin
        row_buf <= dataCf_out;
      end else begin
        row_buf <= row_buf;
      end
      if (finish) begin
        row_ptr <= {PTR_W{1'b0}};
      end else if (we) begin
        row_ptr <= row_ptr + PTR_W'(1);
      end else begin
        row_ptr <= row_ptr;
      end
    end
  end

  c_row_mem #(
    .W  (ROW_W),
    .D  (DEPTH),
    .AW (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (row_ptr),
    .wdata (row_buf)
  );

endmodule

// File: tb/tb_ram_write_controller.sv
// Randomized self-checking bench for ram_write_controller against a row-list model.
module tb_ram_write_controller;
  import ram_wc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             store_C;
  logic             finish;
  logic [ROW_W-1:0] dataCf_out;
  logic             store_C_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: what each row should hold, where the next row goes, whether full.
  logic [ROW_W-1:0] exp_mem [DEPTH];
  int               m_ptr;
  bit               m_full;

  ram_write_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .store_C       (store_C),
    .finish        (finish),
    .dataCf_out    (dataCf_out),
    .store_C_ready (store_C_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < ROW_ELEMS; k++) r[k*ELEM_W +: ELEM_W] = $urandom;
    return r;
  endfunction

  function automatic bit model_req(input logic [ROW_W-1:0] d);
    if (m_full) return 1'b0;
    exp_mem[m_ptr] = d;
    m_ptr++;
    if (m_ptr == DEPTH) m_full = 1'b1;
    return 1'b1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; store_C = 1'b0; finish = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_full = 1'b0;
  endtask

  // One request: store_C high for hi edges then low for lo; counts acknowledges.
  task automatic store_row(input logic [ROW_W-1:0] d, input int hi, input int lo,
                           input bit chg, output int acks, output int first);
    acks = 0; first = -1;
    @(negedge clk);
    dataCf_out = d; store_C = 1'b1;
    for (int c = 1; c <= hi + lo; c++) begin
      @(negedge clk);
      if (c == hi) store_C = 1'b0;
      if (chg && c == 1) dataCf_out = {ROW_W{1'b1}};
      if (store_C_ready === 1'b1) begin
        acks++;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    rst_n = 1'b0; store_C = 1'b0; finish = 1'b0; dataCf_out = {ROW_W{1'b0}};
    repeat (2) @(negedge clk);
    checks++;
    if (store_C_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", store_C_ready); end
    rst_n = 1'b1; m_ptr = 0; m_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (store_C_ready !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL idle_no_ack got %0d acks exp 0", seen); end
    checks++;
    if (dut.row_ptr !== 0) begin errors++; $display("FAIL reset_row_ptr got %0d exp 0", dut.row_ptr); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state); end
  endtask

  task automatic test_single_store();
    logic [ROW_W-1:0] p;
    int a, f;
    bit e;
    for (int k = 0; k < ROW_ELEMS; k++) p[k*ELEM_W +: ELEM_W] = 32'(k + 1);
    store_row(p, 3, 6, 1'b0, a, f);
    e = model_req(p);
    checks++;
    if (a != int'(e)) begin errors++; $display("FAIL single_ack_count got %0d exp %0d", a, e); end
    checks++;
    if (f != 2) begin errors++; $display("FAIL single_ack_latency got %0d exp 2", f); end
    checks++;
    if (dut.u_mem.mem[0] !== exp_mem[0])
      begin errors++; $display("FAIL single_mem0 got[63:0] %h exp[63:0] %h", dut.u_mem.mem[0][63:0], exp_mem[0][63:0]); end
    checks++;
    if (dut.row_ptr !== 1) begin errors++; $display("FAIL single_row_ptr got %0d exp 1", dut.row_ptr); end
  endtask

  task automatic test_repeated();
    logic [ROW_W-1:0] d;
    int a, f, bad = 0;
    apply_reset();
    for (int r = 0; r < 7; r++) begin
      d = {ROW_ELEMS{32'hC000_0000 + 32'(r)}};
      store_row(d, 3, 10, 1'b0, a, f);
      void'(model_req(d));
      checks++;
      if (a != 1 || f != 2) begin errors++; $display("FAIL repeat_ack r=%0d got %0d@%0d exp 1@2", r, a, f); end
    end
    for (int r = 0; r < 7; r++) if (dut.u_mem.mem[r] !== exp_mem[r]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL repeat_mem got %0d bad rows exp 0", bad); end
    checks++;
    if (dut.row_ptr !== 7) begin errors++; $display("FAIL repeat_row_ptr got %0d exp 7", dut.row_ptr); end
  endtask

  task automatic test_data_hold();
    logic [ROW_W-1:0] d;
    int a, f;
    d = rand_row();
    store_row(d, 2, 4, 1'b1, a, f);
    void'(model_req(d));
    checks++;
    if (dut.u_mem.mem[m_ptr-1] !== exp_mem[m_ptr-1])
      begin errors++; $display("FAIL data_hold got[63:0] %h exp[63:0] %h", dut.u_mem.mem[m_ptr-1][63:0], exp_mem[m_ptr-1][63:0]); end
  endtask

  task automatic test_random();
    logic [ROW_W-1:0] d;
    int a, f, bad = 0;
    bit e;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      d = rand_row();
      store_row(d, $urandom_range(1, 4), $urandom_range(2, 6), 1'($urandom_range(0, 1)), a, f);
      e = model_req(d);
      checks++;
      if (a != int'(e)) begin errors++; $display("FAIL random_ack i=%0d got %0d exp %0d", i, a, e); end
    end
    for (int r = 0; r < m_ptr; r++) if (dut.u_mem.mem[r] !== exp_mem[r]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_mem got %0d bad rows exp 0", bad); end
    checks++;
    if (dut.row_ptr !== PTR_W'(m_ptr)) begin errors++; $display("FAIL random_row_ptr got %0d exp %0d", dut.row_ptr, m_ptr); end
  endtask

  task automatic test_full();
    logic [ROW_W-1:0] d;
    int a, f, bad = 0, badm = 0;
    bit e;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = rand_row();
      store_row(d, 1, 2, 1'b0, a, f);
      e = model_req(d);
      if (a != int'(e)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_acks got %0d wrong exp 0", bad); end
    checks++;
    if (dut.state !== FULL) begin errors++; $display("FAIL full_state got %0d exp FULL", dut.state); end
    d = rand_row();
    store_row(d, 2, 4, 1'b0, a, f);
    e = model_req(d);
    checks++;
    if (a != int'(e)) begin errors++; $display("FAIL full_34th_ack got %0d exp %0d", a, e); end
    for (int r = 0; r < DEPTH; r++) if (dut.u_mem.mem[r] !== exp_mem[r]) badm++;
    checks++;
    if (badm != 0) begin errors++; $display("FAIL full_mem got %0d bad rows exp 0", badm); end
    @(negedge clk) finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    m_ptr = 0; m_full = 1'b0;
    checks++;
    if (dut.row_ptr !== 0 || dut.state !== IDLE)
      begin errors++; $display("FAIL full_finish got ptr %0d state %0d exp 0 IDLE", dut.row_ptr, dut.state); end
    d = rand_row();
    store_row(d, 1, 3, 1'b0, a, f);
    e = model_req(d);
    checks++;
    if (a != int'(e) || dut.u_mem.mem[0] !== exp_mem[0])
      begin errors++; $display("FAIL full_rewind_store got ack %0d mem0[63:0] %h exp ack %0d %h", a, dut.u_mem.mem[0][63:0], e, exp_mem[0][63:0]); end
  endtask

  task automatic test_abort();
    logic [ROW_W-1:0] d;
    int a, f;
    apply_reset();
    d = rand_row();
    store_row(d, 1, 3, 1'b0, a, f);
    void'(model_req(d));
    @(negedge clk) finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    m_ptr = 0; m_full = 1'b0;
    // finish during WRITE
    a = 0;
    @(negedge clk); dataCf_out = rand_row(); store_C = 1'b1;
    @(negedge clk); finish = 1'b1; store_C = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) finish = 1'b0;
      if (store_C_ready === 1'b1) a++;
    end
    checks++;
    if (a != 0) begin errors++; $display("FAIL abort_ack got %0d exp 0", a); end
    checks++;
    if (dut.row_ptr !== PTR_W'(m_ptr) || dut.u_mem.mem[0] !== exp_mem[0])
      begin errors++; $display("FAIL abort_state got ptr %0d mem0[63:0] %h exp %0d %h", dut.row_ptr, dut.u_mem.mem[0][63:0], m_ptr, exp_mem[0][63:0]); end
    // finish and request on the same edge
    a = 0;
    @(negedge clk); dataCf_out = rand_row(); store_C = 1'b1; finish = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) finish = 1'b0;
      if (store_C_ready === 1'b1) a++;
    end
    store_C = 1'b0;
    checks++;
    if (a != 0 || dut.row_ptr !== 0 || dut.u_mem.mem[0] !== exp_mem[0])
      begin errors++; $display("FAIL finish_vs_req got acks %0d ptr %0d exp 0 0", a, dut.row_ptr); end
    // async reset while acknowledging
    @(negedge clk);
    d = rand_row(); dataCf_out = d; store_C = 1'b1;
    @(negedge clk); store_C = 1'b0;
    @(negedge clk);
    void'(model_req(d));
    checks++;
    if (store_C_ready !== 1'b1) begin errors++; $display("FAIL pre_reset_ack got %b exp 1", store_C_ready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (store_C_ready !== 1'b0 || dut.row_ptr !== 0)
      begin errors++; $display("FAIL async_reset got ready %b ptr %0d exp 0 0", store_C_ready, dut.row_ptr); end
    @(negedge clk) rst_n = 1'b1;
    m_ptr = 0; m_full = 1'b0;
    d = rand_row();
    store_row(d, 1, 3, 1'b0, a, f);
    void'(model_req(d));
    checks++;
    if (a != 1 || dut.u_mem.mem[0] !== exp_mem[0])
      begin errors++; $display("FAIL post_reset_store got ack %0d mem0[63:0] %h exp 1 %h", a, dut.u_mem.mem[0][63:0], exp_mem[0][63:0]); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_repeated();
    test_data_hold();
    test_random();
    test_full();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
